// File: rtl/mem_read_engine.sv
// Issues MIG READ commands for a host read job and streams the returned words to a client,
// using credits so the read-data FIFO can never overflow. Optional timeout: MEM_READ_TIMEOUT_EN.
module mem_read_engine #(
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_STEP  = 8
`ifdef MEM_READ_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 1023
`endif
) (
    input  logic         clk_ram,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [28:0]  req_addr,
    input  logic [15:0]  req_len,
    output logic [28:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    input  logic [255:0] app_rd_data,
    input  logic         app_rd_data_valid,
    output logic [255:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic         rd_last,
    output logic         done,
    output logic         busy,
    output logic         rd_err
`ifdef MEM_READ_TIMEOUT_EN
    ,
    output logic         rd_timeout
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    cmd_left, rx_left, tx_left;
    logic [CW-1:0]  credits;
    logic           app_en_d, done_d, take;
    logic           fire, pop, out_free, mem_empty, mem_full;
    logic           rx_ok, bypass, push, pop_mem;
    logic           timeout_hit, flush;

    logic [255:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  mem_count;

    // Both handshakes transfer on a cycle where the strobe (app_en / rd_valid) and the
    // accept (app_rdy / rd_ready) are high together; the strobe side holds its payload until then.
    assign fire      = app_en && app_rdy;
    assign pop       = rd_valid && rd_ready;
    assign out_free  = !rd_valid || rd_ready;
    assign mem_empty = (mem_count == '0);
    assign mem_full  = (mem_count == CW'(FIFO_DEPTH));
    assign rx_ok     = app_rd_data_valid && (rx_left != 16'd0) && !mem_full;
    assign bypass    = rx_ok && mem_empty && out_free;
    assign push      = rx_ok && !bypass;
    assign pop_mem   = out_free && !mem_empty;

    assign app_cmd   = 3'b001;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rd_last   = rd_valid && (tx_left == 16'd1);
    assign flush     = timeout_hit;

    always_comb begin
        state_d  = state_q;
        app_en_d = app_en;
        take     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_len == 16'd0) done_d = 1'b1;
                    else                  state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    // A credit is reserved the moment app_en rises, so re-raising needs a fresh one.
                    if (cmd_left > 16'd1 && credits != '0) begin
                        take     = 1'b1;
                        app_en_d = 1'b1;
                    end else begin
                        app_en_d = 1'b0;
                    end
                    if (cmd_left == 16'd1) state_d = DRAIN;
                end else if (!app_en && credits != '0) begin
                    take     = 1'b1;
                    app_en_d = 1'b1;
                end
            end
            DRAIN: begin
                if (tx_left == 16'd0 || (pop && tx_left == 16'd1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) begin
            state_d  = IDLE;
            app_en_d = 1'b0;
            take     = 1'b0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            app_en   <= 1'b0;
            app_addr <= '0;
            cmd_left <= '0;
            rx_left  <= '0;
            tx_left  <= '0;
            credits  <= CW'(FIFO_DEPTH);
            done     <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            app_en  <= app_en_d;
            done    <= done_d;
            credits <= credits - CW'(take) + CW'(pop);
            if (state_q == IDLE && req_valid && req_len != 16'd0) begin
                app_addr <= req_addr;
                cmd_left <= req_len;
                rx_left  <= req_len;
                tx_left  <= req_len;
            end else begin
                if (fire) begin
                    app_addr <= app_addr + 29'(ADDR_STEP);
                    cmd_left <= cmd_left - 16'd1;
                end
                if (rx_ok) rx_left <= rx_left - 16'd1;
                if (pop)   tx_left <= tx_left - 16'd1;
            end
            if (app_rd_data_valid && !rx_ok) rd_err <= 1'b1;
            if (flush) begin
                cmd_left <= '0;
                rx_left  <= '0;
                tx_left  <= '0;
                credits  <= CW'(FIFO_DEPTH);
            end
        end
    end

    always_ff @(posedge clk_ram) begin
        if (push) mem[wr_ptr] <= app_rd_data;
    end

    // Output register is refilled from the FIFO, or straight from the MIG when the FIFO is empty.
    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + AW'(1);
            if (pop_mem) rd_ptr <= rd_ptr + AW'(1);
            mem_count <= mem_count + CW'(push) - CW'(pop_mem);
            if (out_free) begin
                if (!mem_empty) begin
                    rd_data  <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                end else if (bypass) begin
                    rd_data  <= app_rd_data;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_READ_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    logic [TW-1:0] to_cnt;

    // to_cnt holds the number of cycles elapsed since the last returned word.
    assign timeout_hit = (rx_left != 16'd0) && !app_rd_data_valid && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt     <= '0;
            rd_timeout <= 1'b0;
        end else begin
            if (rx_left == 16'd0 || timeout_hit) to_cnt <= '0;
            else if (app_rd_data_valid)          to_cnt <= TW'(1);
            else                                 to_cnt <= to_cnt + TW'(1);
            if (timeout_hit) rd_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_engine.sv
// Bench for mem_read_engine: MIG response model, client-side scoreboard and scenario tasks.
module tb_mem_read_engine;

    logic         clk_ram = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [28:0]  req_addr;
    logic [15:0]  req_len;
    logic [28:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic [255:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic         rd_last;
    logic         done;
    logic         busy;
    logic         rd_err;
`ifdef MEM_READ_TIMEOUT_EN
    logic         rd_timeout;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [256:0] exp_q[$];
    logic [28:0]  exp_addr_q[$];
    int           due_q[$];
    logic [255:0] dat_q[$];

    int cmd_count = 0;
    int pop_count = 0;
    int last_pop_cyc = 0;
    int last_rx_cyc = 0;
    int last_due = 0;
    int job_len = 0;
    int sched_idx = 0;
    int ret_limit = 1000000;
    int lat_min = 2;
    int lat_max = 2;
    bit expect_data = 1'b1;
    bit saw_valid = 1'b0;
    bit prev_hold = 1'b0;
    logic [255:0] prev_data;

    mem_read_engine #(
        .FIFO_DEPTH(4),
        .ADDR_STEP(8)
`ifdef MEM_READ_TIMEOUT_EN
        ,
        .TIMEOUT(50)
`endif
    ) dut (
        .clk_ram(clk_ram),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_len(req_len),
        .app_addr(app_addr),
        .app_cmd(app_cmd),
        .app_en(app_en),
        .app_rdy(app_rdy),
        .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_last(rd_last),
        .done(done),
        .busy(busy),
        .rd_err(rd_err)
`ifdef MEM_READ_TIMEOUT_EN
        ,
        .rd_timeout(rd_timeout)
`endif
    );

    // clock / reset block
    always #5 clk_ram = ~clk_ram;
    always @(posedge clk_ram) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // MIG model: checks every accepted command address and returns data in order after a latency.
    initial begin
        logic [28:0]  a;
        logic [255:0] d;
        int           due;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(negedge clk_ram);
            if (app_en === 1'b1 && app_rdy === 1'b1) begin
                cmd_count++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_addr: unexpected command at app_addr=%h", app_addr);
                end else begin
                    a = exp_addr_q.pop_front();
                    if (app_addr !== a) begin
                        errors++;
                        $display("FAIL cmd_addr: got %h expected %h", app_addr, a);
                    end
                end
                checks++;
                if (app_cmd !== 3'b001) begin
                    errors++;
                    $display("FAIL cmd_code: got %b expected 001", app_cmd);
                end
                if (sched_idx < ret_limit) begin
                    d = rand256();
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    due_q.push_back(due);
                    dat_q.push_back(d);
                    if (expect_data) exp_q.push_back({(sched_idx == job_len - 1), d});
                end
                sched_idx++;
            end
            @(posedge clk_ram);
            #1;
            if (due_q.size() != 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                app_rd_data = dat_q.pop_front();
                app_rd_data_valid = 1'b1;
                last_rx_cyc = cyc;
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    end

    // scoreboard: pops the expected queue on every client transfer, and checks hold-while-stalled
    always @(negedge clk_ram) begin
        logic [256:0] e;
        if (prev_hold && rst_n === 1'b1) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                errors++;
                $display("FAIL hold: rd_valid=%b rd_data=%h expected held %h", rd_valid, rd_data, prev_data);
            end
        end
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            pop_count++;
            last_pop_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word: unexpected word %h", rd_data);
            end else begin
                e = exp_q.pop_front();
                if ({rd_last, rd_data} !== e) begin
                    errors++;
                    $display("FAIL word: got last=%b data=%h expected last=%b data=%h", rd_last, rd_data, e[256], e[255:0]);
                end
            end
        end
        if (rd_valid === 1'b1) saw_valid = 1'b1;
        prev_hold = (rd_valid === 1'b1) && (rd_ready !== 1'b1);
        prev_data = rd_data;
    end

    // driver tasks
    task automatic start_job(input logic [28:0] addr, input logic [15:0] len);
        for (int i = 0; i < int'(len); i++) exp_addr_q.push_back(addr + 29'(i * 8));
        job_len = int'(len);
        sched_idx = 0;
        @(posedge clk_ram);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready: got %b expected 1 before job", req_ready);
        end
        req_valid = 1'b1;
        req_addr = addr;
        req_len = len;
        @(posedge clk_ram);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int dcyc);
        bit seen = 1'b0;
        dcyc = -1;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk_ram);
            #1;
            if (rnd) begin
                rd_ready = 1'($urandom_range(1, 0));
                app_rdy = 1'($urandom_range(1, 0));
            end
            @(negedge clk_ram);
            if (done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_wait: no done pulse within %0d cycles", budget);
        end
        if (rnd) begin
            @(posedge clk_ram);
            #1;
            rd_ready = 1'b1;
            app_rdy = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk_ram);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_ram);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk_ram);
        checks++;
        if ({app_addr, app_cmd, app_en} !== {29'h0, 3'b001, 1'b0}) begin
            errors++;
            $display("FAIL reset_app: got addr=%h cmd=%b en=%b expected 0/001/0", app_addr, app_cmd, app_en);
        end
        checks++;
        if ({req_ready, rd_valid, rd_last, done, busy, rd_err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctl: got ready/valid/last/done/busy/err=%b expected 100000",
                     {req_ready, rd_valid, rd_last, done, busy, rd_err});
        end
    endtask

    task automatic test_basic();
        int dcyc, p0, c0;
        p0 = pop_count;
        c0 = cmd_count;
        start_job(29'h100, 16'd4);
        wait_done(100, 1'b0, dcyc);
        checks++;
        if (dcyc != last_pop_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_cycle: done at %0d expected %0d", dcyc, last_pop_cyc + 1);
        end
        checks++;
        if (pop_count - p0 != 4 || cmd_count - c0 != 4) begin
            errors++;
            $display("FAIL basic_counts: pops=%0d cmds=%0d expected 4/4", pop_count - p0, cmd_count - c0);
        end
        @(negedge clk_ram);
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse: done=%b req_ready=%b expected 0/1", done, req_ready);
        end
    endtask

    task automatic test_backpressure();
        int dcyc, c0;
        c0 = cmd_count;
        rd_ready = 1'b0;
        start_job(29'h2000, 16'd10);
        repeat (40) @(posedge clk_ram);
        #1;
        checks++;
        if (cmd_count - c0 != 4 || app_en !== 1'b0 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL credits: cmds=%0d app_en=%b rd_valid=%b expected 4/0/1", cmd_count - c0, app_en, rd_valid);
        end
        rd_ready = 1'b1;
        wait_done(300, 1'b0, dcyc);
        checks++;
        if (cmd_count - c0 != 10 || rd_err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_finish: cmds=%0d rd_err=%b left=%0d expected 10/0/0", cmd_count - c0, rd_err, exp_q.size());
        end
    endtask

    task automatic test_app_rdy_stall();
        int dcyc, c0;
        bit up = 1'b0;
        c0 = cmd_count;
        app_rdy = 1'b0;
        start_job(29'h300, 16'd1);
        for (int n = 0; n < 20 && !up; n++) begin
            @(posedge clk_ram);
            #1;
            if (app_en === 1'b1) up = 1'b1;
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_ram);
            checks++;
            if (app_en !== 1'b1 || app_addr !== 29'h300) begin
                errors++;
                $display("FAIL stall_hold: app_en=%b app_addr=%h expected 1/300", app_en, app_addr);
            end
        end
        @(posedge clk_ram);
        #1;
        checks++;
        if (cmd_count - c0 != 0) begin
            errors++;
            $display("FAIL stall_count: %0d commands counted while app_rdy=0, expected 0", cmd_count - c0);
        end
        app_rdy = 1'b1;
        wait_done(100, 1'b0, dcyc);
        checks++;
        if (cmd_count - c0 != 1) begin
            errors++;
            $display("FAIL stall_cmds: got %0d commands expected 1", cmd_count - c0);
        end
    endtask

    task automatic test_len_zero();
        int c0;
        bit en_seen = 1'b0;
        c0 = cmd_count;
        @(posedge clk_ram);
        #1;
        req_valid = 1'b1;
        req_addr = 29'h777;
        req_len = 16'd0;
        @(posedge clk_ram);
        #1;
        req_valid = 1'b0;
        @(negedge clk_ram);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: done=%b busy=%b expected 1/0", done, busy);
        end
        @(negedge clk_ram);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL len0_pulse: done=%b expected 0", done);
        end
        repeat (5) begin
            @(negedge clk_ram);
            if (app_en !== 1'b0) en_seen = 1'b1;
        end
        @(posedge clk_ram);
        #1;
        checks++;
        if (en_seen || cmd_count != c0) begin
            errors++;
            $display("FAIL len0_cmd: app_en_seen=%b cmds=%0d expected 0/0", en_seen, cmd_count - c0);
        end
    endtask

    task automatic test_addr_wrap();
        int dcyc;
        start_job(29'h1FFFFFF8, 16'd2);
        wait_done(100, 1'b0, dcyc);
        checks++;
        if (exp_addr_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_finish: addrs_left=%0d words_left=%0d expected 0/0", exp_addr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int dcyc;
        lat_min = 1;
        lat_max = 5;
        start_job(29'h1000, 16'd9);
        wait_done(2000, 1'b1, dcyc);
        start_job(29'h1FFFFFC0, 16'd13);
        wait_done(2000, 1'b1, dcyc);
        lat_min = 2;
        lat_max = 2;
        checks++;
        if (exp_q.size() != 0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL random_finish: words_left=%0d rd_err=%b expected 0/0", exp_q.size(), rd_err);
        end
    endtask

    task automatic test_reset_mid_job();
        int c0;
        bit hit = 1'b0;
        c0 = cmd_count;
        lat_min = 10;
        lat_max = 10;
        expect_data = 1'b0;
        saw_valid = 1'b0;
        start_job(29'h400, 16'd8);
        for (int n = 0; n < 50 && !hit; n++) begin
            @(posedge clk_ram);
            #1;
            if (cmd_count - c0 >= 3) hit = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({app_en, busy, req_ready, rd_valid} !== 4'b0010 || app_addr !== 29'h0) begin
            errors++;
            $display("FAIL abort_async: en/busy/ready/valid=%b addr=%h expected 0010/0", {app_en, busy, req_ready, rd_valid}, app_addr);
        end
        repeat (2) @(posedge clk_ram);
        #1;
        rst_n = 1'b1;
        exp_addr_q.delete();
        for (int n = 0; n < 40 && due_q.size() != 0; n++) @(posedge clk_ram);
        repeat (3) @(posedge clk_ram);
        #1;
        checks++;
        if (rd_err !== 1'b1 || saw_valid || cmd_count - c0 != 3) begin
            errors++;
            $display("FAIL stray: rd_err=%b saw_valid=%b cmds=%0d expected 1/0/3", rd_err, saw_valid, cmd_count - c0);
        end
        lat_min = 2;
        lat_max = 2;
        expect_data = 1'b1;
        apply_reset();
        @(negedge clk_ram);
        checks++;
        if (rd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: rd_err=%b expected 0 after reset", rd_err);
        end
    endtask

`ifdef MEM_READ_TIMEOUT_EN
    task automatic test_timeout();
        int dcyc;
        ret_limit = 1;
        start_job(29'h500, 16'd2);
        wait_done(300, 1'b0, dcyc);
        checks++;
        if (dcyc != last_rx_cyc + 50 || rd_timeout !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout: done_cycle=%0d expected %0d rd_timeout=%b req_ready=%b expected 1/1",
                     dcyc, last_rx_cyc + 50, rd_timeout, req_ready);
        end
        ret_limit = 1000000;
        exp_addr_q.delete();
        start_job(29'h600, 16'd4);
        wait_done(100, 1'b0, dcyc);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_recover: words_left=%0d expected 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_len = '0;
        app_rdy = 1'b1;
        rd_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_app_rdy_stall();
        test_len_zero();
        test_addr_wrap();
        test_random();
        test_reset_mid_job();
`ifdef MEM_READ_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(posedge clk_ram);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_read_engine.md
Name: mem_read_engine

Overview:
- Read-back counterpart to the capture write arbiter.
- Accepts a read job (start address, length in 256-bit words) from the readout/host side and issues READ commands on the MIG app interface in the clk_ram domain.
- Buffers returned app_rd_data in an internal FIFO, because the MIG cannot be back-pressured.
- Delivers the words to the client on a valid/ready stream.
- Credit-based issue guarantees the FIFO never overflows.

Parameters:
FIFO_DEPTH, 32, read data FIFO depth in 256-bit words; power of two, 4..512
ADDR_STEP, 8, app_addr increment per READ command (BL8 on 32-bit DRAM)

Ports:
clk_ram  in  1  controller user clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  read job request
req_ready  out  1  engine idle, can accept job
req_addr  in  29  start app_addr of job
req_len  in  16  job length in 256-bit words; 0 legal
app_addr  out  29  MIG command address
app_cmd  out  3  MIG command; always 3'b001 (READ)
app_en  out  1  MIG command strobe
app_rdy  in  1  MIG command accept
app_rd_data  in  256  MIG read data
app_rd_data_valid  in  1  MIG read data strobe
rd_data  out  256  client data
rd_valid  out  1  client data valid
rd_ready  in  1  client accept
rd_last  out  1  marks final word of job
done  out  1  one-cycle pulse at job completion
busy  out  1  high while state != IDLE
rd_err  out  1  sticky error: stray or overflowing read data

Behaviour:
- Reset values: app_addr=0, app_cmd=3'b001, app_en=0, req_ready=1, rd_valid=0, rd_last=0, done=0, busy=0, rd_err=0. FIFO empty; credits=FIFO_DEPTH; state IDLE.
- Registers: cmd_left (16b), rx_left (16b), tx_left (16b), credits (log2(FIFO_DEPTH)+1 bits).
- IDLE:
  - req_ready=1.
  - On req_valid with req_len==0: accept; done pulses next cycle; stay IDLE; no commands issued.
  - On req_valid with req_len!=0: latch app_addr=req_addr and cmd_left=rx_left=tx_left=req_len; go to ISSUE.
- ISSUE:
  - When app_en==0 and credits>0: set app_en=1 and decrement credits (reservation).
  - app_en, app_addr and app_cmd hold stable until a cycle with app_en && app_rdy. That cycle:
    - app_addr += ADDR_STEP, modulo 2^29 (wrap, no error).
    - cmd_left--.
    - app_en deasserts the next cycle unless re-raised. Back-to-back issue is allowed: if credits>0 and cmd_left>1, app_en stays 1 and credits decrement again.
  - When cmd_left reaches 0: go to DRAIN.
- DRAIN: when tx_left reaches 0, pulse done and go to IDLE.
- Receive:
  - app_rd_data_valid with rx_left>0: write FIFO, rx_left--.
  - app_rd_data_valid with rx_left==0, or with FIFO full: discard word, set rd_err.
- Client side:
  - rd_data/rd_valid come from a registered FIFO output; first word reaches rd_valid 1 cycle after its app_rd_data_valid when the FIFO is empty.
  - rd_data/rd_valid hold stable while rd_valid && !rd_ready.
  - Each rd_valid && rd_ready: credits++, tx_left--.
  - rd_last = rd_valid && (tx_left==1).
- Credit rule: reserved+outstanding+buffered words never exceed FIFO_DEPTH. The same-cycle credit increment and decrement net to zero.
- Simultaneous events: req_valid is ignored outside IDLE. Final pop and done occur on the same edge as the DRAIN→IDLE transition, so a new job can be accepted the following cycle.
- Reset mid-job:
  - Everything returns to reset values immediately and app_en drops asynchronously.
  - Late MIG data for the aborted job arrives with rx_left==0, is discarded, and sets rd_err.
  - rd_err clears only on reset.

Optional Feature:
MEM_READ_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT (default 1023) and output rd_timeout (1b, sticky, reset 0).
  - A 10-bit-min counter runs while rx_left>0 and resets on every app_rd_data_valid.
  - On reaching TIMEOUT: set rd_timeout, force rx_left=tx_left=0, flush FIFO, restore credits=FIFO_DEPTH, pulse done, go to IDLE.
- Undefined: no counter, no port; the engine waits indefinitely.

Test Plan:
- Basic read: job addr=0x100, len=4; app_rdy=1, MIG returns data 2 cycles after each command -> app_addr 0x100,0x108,0x110,0x118 each accepted once; client receives 4 words in order; rd_last on the 4th; done 1 cycle after the 4th pop.
- Backpressure and credits: FIFO_DEPTH=4, len=10, rd_ready=0 -> exactly 4 commands issued, then app_en stays 0. Raising rd_ready resumes issue; all 10 words delivered; rd_err=0.
- app_rdy stall: app_rdy=0 for 5 cycles while app_en=1 -> app_addr and app_en held stable; exactly one command counted once app_rdy=1.
- Edge cases: len=0 -> done pulse next cycle, app_en never asserted. Job with addr=0x1FFFFFF8, len=2 -> second address 0x0000000.
- Stray data and reset: reset asserted mid-job with 3 reads outstanding -> outputs at reset values immediately; 3 late app_rd_data_valid beats discarded; rd_err=1; rd_valid stays 0.
- Timeout (MEM_READ_TIMEOUT_EN, TIMEOUT=50): job len=2, MIG returns only 1 word -> rd_timeout=1 and done pulse 50 cycles after that word; req_ready=1 again.
